// File: rtl/ramp_adc_driver.sv
// ramp_adc_driver
//   Drive side of a single-slope ADC. A first-order sigma-delta bitstream
//   (filtered off-chip) forms the reference ramp, a discharge output dumps
//   the ramp capacitor before each ramp, and the synchronized comparator
//   result freezes the ramp code at the crossing.
//
// Ports
//   i_clk             system clock, rising edge
//   i_rst_n           asynchronous active-low reset
//   i_start           one-cycle conversion request (honoured only in IDLE)
//   i_step_div        clocks per ramp step minus 1, latched on accepted start
//   i_code_max        final ramp code, latched on accepted start
//   i_comp_in         comparator result, asynchronous to i_clk
//   o_busy            conversion in progress (DISCHARGE, RAMP, DONE)
//   o_done            one-cycle end-of-conversion pulse
//   o_captured_code   ramp code at the crossing (code_max on timeout)
//   o_captured_valid  last conversion saw a crossing
//   o_timeout         last conversion hit the top of the ramp uncrossed
//   o_dac_out         sigma-delta ramp bitstream
//   o_discharge       ramp-capacitor dump enable
//   o_dbg_state       current FSM state, for observation only
//
// Handshake: i_start is a single-cycle request sampled on a rising edge;
// it is accepted only while o_busy is low and ignored otherwise. There is
// no back-pressure on the result: o_done is a one-cycle pulse and the
// captured_* / timeout outputs hold until the next accepted start.

module ramp_adc_driver #(
    parameter int CODE_W           = 8,
    parameter int DIV_W            = 8,
    parameter int DISCHARGE_CYCLES = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DIV_W-1:0]  i_step_div,
    input  logic [CODE_W-1:0] i_code_max,
    input  logic              i_comp_in,
    output logic              o_busy,
    output logic              o_done,
    output logic [CODE_W-1:0] o_captured_code,
    output logic              o_captured_valid,
    output logic              o_timeout,
    output logic              o_dac_out,
    output logic              o_discharge,
    output logic [1:0]        o_dbg_state
);

    localparam int DIS_W = $clog2(DISCHARGE_CYCLES + 1);
    localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(DISCHARGE_CYCLES - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_DISCHARGE = 2'd1;
    localparam logic [1:0] S_RAMP      = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    logic [1:0]        r_state;
    logic [DIS_W-1:0]  r_dis_cnt;
    logic [DIV_W-1:0]  r_step_cnt;
    logic [DIV_W-1:0]  r_step_div;
    logic [CODE_W-1:0] r_code_max;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W:0]   r_acc;
    logic [CODE_W-1:0] r_captured_code;
    logic              r_captured_valid;
    logic              r_timeout;
    logic              r_comp_meta;
    logic              r_comp_s;

    logic              w_in_ramp;
    logic              w_step_end;

    assign w_in_ramp  = (r_state == S_RAMP);
    assign w_step_end = (r_step_cnt == r_step_div);

    // Two-flop synchronizer for the asynchronous comparator; free-running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_comp_meta <= 1'b0;
            r_comp_s    <= 1'b0;
        end else begin
            r_comp_meta <= i_comp_in;
            r_comp_s    <= r_comp_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_dis_cnt        <= '0;
            r_step_cnt       <= '0;
            r_step_div       <= '0;
            r_code_max       <= '0;
            r_code           <= '0;
            r_captured_code  <= '0;
            r_captured_valid <= 1'b0;
            r_timeout        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_step_div       <= i_step_div;
                        r_code_max       <= i_code_max;
                        r_captured_valid <= 1'b0;
                        r_timeout        <= 1'b0;
                        r_dis_cnt        <= '0;
                        r_state          <= S_DISCHARGE;
                    end
                end
                S_DISCHARGE: begin
                    r_code     <= '0;
                    r_step_cnt <= '0;
                    if (r_dis_cnt == DIS_LAST) begin
                        r_state <= S_RAMP;
                    end else begin
                        r_dis_cnt <= r_dis_cnt + 1'b1;
                    end
                end
                S_RAMP: begin
                    // Crossing is tested first so it wins over top-of-ramp
                    // when both happen in the same cycle.
                    if (r_comp_s) begin
                        r_captured_code  <= r_code;
                        r_captured_valid <= 1'b1;
                        r_state          <= S_DONE;
                    end else if (w_step_end) begin
                        r_step_cnt <= '0;
                        // The top code is held for one full step before
                        // timing out, so code never passes code_max.
                        if (r_code == r_code_max) begin
                            r_captured_code <= r_code_max;
                            r_timeout       <= 1'b1;
                            r_state         <= S_DONE;
                        end else begin
                            r_code <= r_code + 1'b1;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_code  <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // First-order sigma-delta: the carry out of the low CODE_W bits is the
    // bitstream. Clearing during discharge gives every ramp the same residue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (r_state == S_DISCHARGE) begin
            r_acc <= '0;
        end else begin
            r_acc <= {1'b0, r_acc[CODE_W-1:0]} + {1'b0, r_code};
        end
    end

    assign o_busy           = (r_state != S_IDLE);
    assign o_done           = (r_state == S_DONE);
    assign o_discharge      = (r_state == S_DISCHARGE);
    assign o_dac_out        = w_in_ramp & r_acc[CODE_W];
    assign o_captured_code  = r_captured_code;
    assign o_captured_valid = r_captured_valid;
    assign o_timeout        = r_timeout;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_ramp_adc_driver.sv
// Directed bench for ramp_adc_driver. Expected conversion results
// {captured_valid, timeout, captured_code} are queued when a conversion is
// started and compared when the done pulse appears.

module tb_ramp_adc_driver;

    localparam int CODE_W = 8;
    localparam int DIV_W  = 8;
    localparam int DIS_N  = 64;
    localparam int RES_W  = CODE_W + 2;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic start   = 1'b0;
    logic comp_in = 1'b0;
    logic [DIV_W-1:0]  step_div = '0;
    logic [CODE_W-1:0] code_max = '0;

    logic              o_busy;
    logic              o_done;
    logic [CODE_W-1:0] o_captured_code;
    logic              o_captured_valid;
    logic              o_timeout;
    logic              o_dac_out;
    logic              o_discharge;
    logic [1:0]        o_dbg_state;

    always #5 clk = ~clk;

    ramp_adc_driver #(
        .CODE_W(CODE_W),
        .DIV_W(DIV_W),
        .DISCHARGE_CYCLES(DIS_N)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_step_div(step_div),
        .i_code_max(code_max),
        .i_comp_in(comp_in),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_captured_code(o_captured_code),
        .o_captured_valid(o_captured_valid),
        .o_timeout(o_timeout),
        .o_dac_out(o_dac_out),
        .o_discharge(o_discharge),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [RES_W-1:0] exp_q[$];
    int cnt_lag[256];
    int cnt_al[256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge while IDLE; returns at the negedge of the first
    // discharge cycle. Inputs are scrambled afterwards to prove latching.
    task automatic start_conv(input logic [DIV_W-1:0] div, input logic [CODE_W-1:0] cmax);
        start    = 1'b1;
        step_div = div;
        code_max = cmax;
        @(negedge clk);
        start    = 1'b0;
        step_div = DIV_W'($urandom_range(0, 255));
        code_max = CODE_W'($urandom_range(0, 255));
        check("busy_after_start", o_busy, 1);
        check("discharge_after_start", o_discharge, 1);
    endtask

    // Counts discharge cycles; optionally pulses start at cycle 'poke'.
    task automatic measure_discharge(input int poke, output int n);
        int dac_ones;
        n = 0;
        dac_ones = 0;
        while (o_discharge && n < 1000) begin
            start = (n == poke);
            if (o_dac_out) dac_ones++;
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check("discharge_len", n, DIS_N);
        check("dac_during_discharge", dac_ones, 0);
    endtask

    // Runs the ramp until done. comp_in rises at ramp cycle comp_at, start
    // is pulsed at ramp cycle poke, and dac ones are tallied when dac=1.
    task automatic wait_done(input int comp_at, input int poke, input bit dac, output int t);
        t = 0;
        while (!o_done && t < 70000) begin
            if (t == comp_at) comp_in = 1'b1;
            start = (t == poke);
            if (dac && o_dac_out && t < 65536) begin
                if (t >= 1) cnt_lag[(t-1)/256]++;
                cnt_al[t/256]++;
            end
            t++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // At the done cycle: compare against the queued result, then step into
    // the first IDLE cycle.
    task automatic finish_conv(input int t, input int exp_ramp);
        logic [RES_W-1:0] exp_res;
        check("ramp_len", t, exp_ramp);
        check("done_high", o_done, 1);
        if (exp_q.size() == 0) begin
            check("queue_nonempty", 0, 1);
        end else begin
            exp_res = exp_q.pop_front();
            check("result", {o_captured_valid, o_timeout, o_captured_code}, exp_res);
        end
        comp_in = 1'b0;
        @(negedge clk);
        check("done_one_cycle", o_done, 0);
        check("busy_falls", o_busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {o_busy, o_done, o_captured_code, o_captured_valid,
                    o_timeout, o_dac_out, o_discharge}, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int t;
        int ks[4];
        ks = '{0, 1, 64, 128};
        foreach (cnt_lag[i]) begin
            cnt_lag[i] = 0;
            cnt_al[i]  = 0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Timeout: code_max=3, step_div=1 -> codes 0,0,1,1,2,2,3,3.
        // Start pokes in DISCHARGE and RAMP must be ignored.
        exp_q.push_back({1'b0, 1'b1, 8'd3});
        start_conv(8'd1, 8'd3);
        measure_discharge(10, n);
        wait_done(-1, 3, 1'b0, t);
        finish_conv(t, 8);
        check("timeout_held", o_timeout, 1);

        // Early crossing, started in the first IDLE cycle after done.
        comp_in = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 8'd0});
        start_conv(8'd3, 8'd10);
        check("timeout_cleared", o_timeout, 0);
        measure_discharge(-1, n);
        wait_done(-1, -1, 1'b0, t);
        finish_conv(t, 1);

        // Crossing at code 100 with step_div=0: two synchronizer cycles
        // later the code is 102. Started in the first IDLE cycle again.
        exp_q.push_back({1'b1, 1'b0, 8'd102});
        start_conv(8'd0, 8'd255);
        check("valid_cleared", o_captured_valid, 0);
        measure_discharge(-1, n);
        wait_done(100, -1, 1'b0, t);
        finish_conv(t, 103);
        repeat (5) @(negedge clk);
        check("result_hold", {o_captured_valid, o_timeout, o_captured_code},
              {1'b1, 1'b0, 8'd102});

        // Reset mid-RAMP: outputs clear immediately, no done pulse.
        start_conv(8'd0, 8'd200);
        measure_discharge(-1, n);
        repeat (50) @(negedge clk);
        check("busy_mid_ramp", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_ramp");
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_done) n++;
        end
        check("no_done_in_reset", n, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full discharge again, then the DAC density ramp (256 x 256).
        exp_q.push_back({1'b0, 1'b1, 8'd255});
        start_conv(8'd255, 8'd255);
        measure_discharge(-1, n);
        wait_done(-1, -1, 1'b1, t);
        finish_conv(t, 65536);
        // dac_out is the carry of the previous cycle's add, so the window
        // for code k is shifted one cycle later than the step itself.
        foreach (ks[i]) begin
            check($sformatf("dac_density_k%0d", ks[i]), cnt_lag[ks[i]], ks[i]);
        end
        // The last ramp carry lands in DONE where the output is blanked;
        // the accumulator returns to zero at each step boundary, so the
        // step-aligned window at k=255 also holds 255 ones.
        check("dac_density_k255", cnt_al[255], 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: observed no finish, expected finish before 1500000");
        $fatal(1, "watchdog expired");
    end

endmodule
